// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle MIPS datapath with a shared fetch/data memory port.
// Moore-style step per clock, except that FETCH qualifies IRWrite/PCWrite with MemReady.
// Memory states wait on MemReady; illegal opcodes or a memory timeout park the FSM in
// HALT with a sticky fault code until reset.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Function,
  input  logic       MemReady,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic [3:0] State,
  output logic [1:0] Fault
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StRWb      = 4'd7,
    StExecI    = 4'd8,
    StIWb      = 4'd9,
    StBranch   = 4'd10,
    StJump     = 4'd11,
    StJal      = 4'd12,
    StJr       = 4'd13,
    StUnused   = 4'd14,
    StHalt     = 4'd15
  } stateT;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [1:0] FaultNone    = 2'b00;
  localparam logic [1:0] FaultIllegal = 2'b01;
  localparam logic [1:0] FaultTimeout = 2'b10;

  localparam logic [TIMEOUT_WIDTH-1:0] TimeoutVal = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  stateT                    stateQ, stateD;
  logic [1:0]               faultQ, faultD;
  logic [TIMEOUT_WIDTH-1:0] waitCntQ, waitCntD;
  logic                     inMemState;
  logic                     timedOut;

  // Zero feeds the datapath's branch-condition logic, not the sequencer.
  logic unusedZero;
  assign unusedZero = Zero;

  // State, sticky fault and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= StFetch;
      faultQ   <= FaultNone;
      waitCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      faultQ   <= faultD;
      waitCntQ <= waitCntD;
    end
  end

  // Next-state decode, including the memory timeout override.
  always_comb begin
    stateD     = stateQ;
    faultD     = faultQ;
    inMemState = (stateQ == StFetch) || (stateQ == StMemRead) || (stateQ == StMemWrite);
    // A ready in the timeout cycle still completes the transfer.
    timedOut   = TimeoutEn && inMemState && !MemReady && (waitCntQ == TimeoutVal);

    case (stateQ)
      StFetch:    if (MemReady) stateD = StDecode;
      StDecode: begin
        case (OP)
          OpRType:                      stateD = (Function == FnJr) ? StJr : StExecR;
          OpAddi, OpAndi, OpOri, OpLui: stateD = StExecI;
          OpLw, OpSw:                   stateD = StMemAddr;
          OpBeq, OpBne:                 stateD = StBranch;
          OpJ:                          stateD = StJump;
          OpJal:                        stateD = StJal;
          default: begin
            stateD = StHalt;
            faultD = FaultIllegal;
          end
        endcase
      end
      StMemAddr:  stateD = (OP == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (MemReady) stateD = StMemWb;
      StMemWrite: if (MemReady) stateD = StFetch;
      StExecR:    stateD = StRWb;
      StExecI:    stateD = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump, StJal, StJr: stateD = StFetch;
      StHalt:     stateD = StHalt;
      default: begin
        stateD = StHalt;
        faultD = FaultIllegal;
      end
    endcase

    if (timedOut) begin
      stateD = StHalt;
      faultD = FaultTimeout;
    end
  end

  // Wait counter: restarts on any state change, saturates so a disabled timeout never wraps.
  always_comb begin
    waitCntD = waitCntQ;
    if (stateD != stateQ) begin
      waitCntD = '0;
    end else if (inMemState && !MemReady && (waitCntQ != '1)) begin
      waitCntD = waitCntQ + 1'b1;
    end
  end

  // Per-state control outputs; everything forced low while reset is asserted.
  always_comb begin
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    State       = stateQ;
    Fault       = faultQ;

    if (reset) begin
      case (stateQ)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        StDecode:   ALUSrcB = 2'b11;
        StMemAddr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRead: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        StMemWrite: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StExecR: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        StRWb: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
        end
        StExecI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (OP)
            OpAndi:  ALUOp = 3'b100;
            OpOri:   ALUOp = 3'b011;
            OpLui:   ALUOp = 3'b101;
            default: ALUOp = 3'b000;
          endcase
        end
        StIWb:      RegWrite = 1'b1;
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          BranchNE    = (OP == OpBne);
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        StJal: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        StJr: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each instruction is expanded into a per-cycle trace of expected control
// words from the instruction's class and memory wait counts; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  localparam int unsigned Timeout = 4;

  localparam int CR   = 0;
  localparam int CJr  = 1;
  localparam int CI   = 2;
  localparam int CLw  = 3;
  localparam int CSw  = 4;
  localparam int CBr  = 5;
  localparam int CJ   = 6;
  localparam int CJal = 7;
  localparam int CIll = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OP = 6'h00;
  logic [5:0] Function = 6'h00;
  logic       MemReady = 1'b0;
  logic       Zero = 1'b0;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNE;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg, Fault;
  logic       ALUSrcA, RegWrite;
  logic [2:0] ALUOp;
  logic [3:0] State;

  multicycle_control_fsm #(
    .TIMEOUT_CYCLES(Timeout),
    .TIMEOUT_WIDTH (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .OP         (OP),
    .Function   (Function),
    .MemReady   (MemReady),
    .Zero       (Zero),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .BranchNE   (BranchNE),
    .PCSource   (PCSource),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .State      (State),
    .Fault      (Fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic       bne;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic       rw;
    logic [1:0] fault;
  } ctlT;

  ctlT        expQ[$];
  int         nCompared = 0;
  int         nMismatch = 0;

  ctlT        trE[$];
  logic       trR[$];
  logic [5:0] curOp;
  logic [1:0] curFault = 2'b00;

  // Control word each step must present, straight from the per-step table.
  function automatic ctlT ctlFor(int st, logic rdy);
    ctlT c;
    c = '0;
    c.st = 4'(st);
    c.fault = curFault;
    case (st)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 2'b01; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = 3'b010; end
      7:  begin c.rw = 1; c.regdst = 2'b01; end
      8:  begin
        c.srca = 1;
        c.srcb = 2'b10;
        c.aluop = (curOp == 6'h0C) ? 3'b100 : (curOp == 6'h0D) ? 3'b011 :
                  (curOp == 6'h0F) ? 3'b101 : 3'b000;
      end
      9:  c.rw = 1;
      10: begin
        c.srca = 1; c.aluop = 3'b001; c.pcwc = 1; c.pcsrc = 2'b01;
        c.bne = (curOp == 6'h05);
      end
      11: begin c.pcw = 1; c.pcsrc = 2'b10; end
      12: begin c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1; c.regdst = 2'b10; c.m2r = 2'b10; end
      13: begin c.pcw = 1; c.pcsrc = 2'b11; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit isLegal(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F,
                      6'h23, 6'h2B};
  endfunction

  task automatic addStep(int st, logic rdy);
    trE.push_back(ctlFor(st, rdy));
    trR.push_back(rdy);
  endtask

  // w idle cycles then a ready; more than Timeout idle cycles means a timeout instead.
  task automatic memPhase(int st, int w, output bit timedOut);
    if (w > int'(Timeout)) begin
      repeat (Timeout + 1) addStep(st, 1'b0);
      timedOut = 1'b1;
    end else begin
      repeat (w) addStep(st, 1'b0);
      addStep(st, 1'b1);
      timedOut = 1'b0;
    end
  endtask

  task automatic addHalt(logic [1:0] f, int n);
    curFault = f;
    repeat (n) addStep(15, 1'($urandom));
  endtask

  task automatic driveCycle(ctlT e, logic rdy);
    reset = 1'b1;
    MemReady = rdy;
    Zero = 1'($urandom);
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycles(int n);
    repeat (n) begin
      reset = 1'b0;
      MemReady = 1'($urandom);
      expQ.push_back('0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    curFault = 2'b00;
  endtask

  task automatic runInstr(int cls, logic [5:0] op, logic [5:0] fn, int wf, int wm,
                          int haltLen, int abortAt);
    bit to;
    bit halted;
    int n;
    trE.delete();
    trR.delete();
    curOp = op;
    OP = op;
    Function = fn;
    halted = 1'b0;
    memPhase(0, wf, to);
    if (to) begin
      addHalt(2'b10, haltLen);
      halted = 1'b1;
    end else begin
      addStep(1, 1'($urandom));
      case (cls)
        CR:   begin addStep(6, 1'($urandom)); addStep(7, 1'($urandom)); end
        CJr:  addStep(13, 1'($urandom));
        CI:   begin addStep(8, 1'($urandom)); addStep(9, 1'($urandom)); end
        CLw: begin
          addStep(2, 1'($urandom));
          memPhase(3, wm, to);
          if (to) begin addHalt(2'b10, haltLen); halted = 1'b1; end
          else addStep(4, 1'($urandom));
        end
        CSw: begin
          addStep(2, 1'($urandom));
          memPhase(5, wm, to);
          if (to) begin addHalt(2'b10, haltLen); halted = 1'b1; end
        end
        CBr:  addStep(10, 1'($urandom));
        CJ:   addStep(11, 1'($urandom));
        CJal: addStep(12, 1'($urandom));
        default: begin addHalt(2'b01, haltLen); halted = 1'b1; end
      endcase
    end
    n = trE.size();
    if (abortAt > 0 && abortAt < n) begin
      n = abortAt;
      halted = 1'b1;
    end
    for (int i = 0; i < n; i++) driveCycle(trE[i], trR[i]);
    if (halted) resetCycles(1 + $urandom_range(0, 1));
  endtask

  function automatic int pickWait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 16) return r - 11;
    if (r < 18) return int'(Timeout);
    return int'(Timeout) + 1 + (r - 18);
  endfunction

  // Monitor: compare every presented cycle against the oldest expected control word.
  always @(negedge clk) begin
    ctlT act;
    ctlT want;
    if (expQ.size() != 0) begin
      want = expQ.pop_front();
      act = {State, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNE,
             PCSource, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, Fault};
      nCompared++;
      if (act !== want) begin
        nMismatch++;
        $display("FAIL ctl_word t=%0t state=%0d: got %h required %h", $time, want.st, act,
                 want);
      end
    end
  end

  initial begin
    int cls;
    logic [5:0] op;
    logic [5:0] fn;
    @(posedge clk);
    #1;
    resetCycles(2);

    // Directed cases.
    runInstr(CR, 6'h00, 6'h20, 0, 0, 0, 0);
    runInstr(CLw, 6'h23, 6'h00, 0, 3, 0, 0);
    runInstr(CBr, 6'h05, 6'h00, 0, 0, 0, 0);
    runInstr(CJal, 6'h03, 6'h00, 0, 0, 0, 0);
    runInstr(CIll, 6'h3F, 6'h00, 0, 0, 22, 0);
    runInstr(CR, 6'h00, 6'h20, 5, 0, 6, 0);
    runInstr(CSw, 6'h2B, 6'h00, int'(Timeout), int'(Timeout), 0, 0);
    runInstr(CLw, 6'h23, 6'h00, 0, int'(Timeout) + 1, 4, 0);
    runInstr(CJr, 6'h00, 6'h08, 1, 0, 0, 0);
    runInstr(CI, 6'h0F, 6'h00, 0, 0, 0, 0);
    runInstr(CLw, 6'h23, 6'h00, 0, 2, 0, 5);

    // Randomized instruction stream.
    for (int k = 0; k < 300; k++) begin
      cls = $urandom_range(0, 8);
      fn = 6'($urandom);
      case (cls)
        CR: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
        CJr:  begin op = 6'h00; fn = 6'h08; end
        CI: begin
          case ($urandom_range(0, 3))
            0: op = 6'h08;
            1: op = 6'h0C;
            2: op = 6'h0D;
            default: op = 6'h0F;
          endcase
        end
        CLw:  op = 6'h23;
        CSw:  op = 6'h2B;
        CBr:  op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
        CJ:   op = 6'h02;
        CJal: op = 6'h03;
        default: begin
          op = 6'($urandom);
          while (isLegal(op)) op = 6'($urandom);
        end
      endcase
      runInstr(cls, op, fn, pickWait(), pickWait(), $urandom_range(1, 5),
               ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0);
    end

    @(negedge clk);
    #1;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatch++;
      $display("FAIL drain: %0d expected cycles left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
